// File: rtl/dat_mem_seq.sv
// Single-port data memory with combinational read, clocked write and a one-word-per-cycle
// hardware clear sweep after reset or start. Optional macro DAT_MEM_PARITY_EN adds a parity bit per word.
module dat_mem_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] dat_in,
    output logic [WIDTH-1:0] dat_out,
    output logic             busy,
    output logic             done,
    output logic             wr_drop,
    output logic             par_err
);

`ifdef DAT_MEM_PARITY_EN
    localparam int unsigned MW = WIDTH + 1;
`else
    localparam int unsigned MW = WIDTH;
`endif
    localparam int unsigned AW1 = AW + 1;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [MW-1:0]    core_q [DEPTH];

    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wr_drop_q, wr_drop_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [MW-1:0]    mem_wdata;

    logic             in_range;
    logic             rd_valid;
    logic [MW-1:0]    rd_word;

    // Stored word: data, plus its even-parity bit when parity is enabled.
    function automatic logic [MW-1:0] encode(input logic [WIDTH-1:0] d);
`ifdef DAT_MEM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    assign in_range = ({1'b0, addr} < AW1'(DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Sequencer: the clear sweep and user writes share the single write port.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wr_drop_d = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + AW'(1);
                wr_drop_d = wr_en;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_READY;
                    clr_cnt_d = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            ST_READY: begin
                if (start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    busy_d    = 1'b1;
                    wr_drop_d = wr_en;
                end else if (wr_en) begin
                    if (in_range) begin
                        mem_we    = 1'b1;
                        mem_waddr = addr;
                        mem_wdata = encode(dat_in);
                    end else begin
                        wr_drop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
                busy_d    = 1'b1;
            end
        endcase
    end

    // Array storage carries no reset so it maps onto a plain RAM macro.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            core_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_word  = core_q[addr];
    assign rd_valid = (state_q == ST_READY) && in_range;
    assign dat_out  = rd_valid ? rd_word[WIDTH-1:0] : '0;

`ifdef DAT_MEM_PARITY_EN
    assign par_err = rd_valid && (^rd_word);
`else
    assign par_err = 1'b0;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign wr_drop = wr_drop_q;

endmodule
